// File: rtl/seq_adder_param_if.sv
// rtl/seq_adder_param_if.sv - request/result bundle for the chunked sequential adder
//
// Signals (directions given for the slave, i.e. the adder):
//   start        in   request; accepted only while the adder is idle
//   sub          in   0 = a+b, 1 = a-b; sampled with start
//   abort        in   synchronous cancel of a running operation
//   a, b         in   WIDTH-bit operands, sampled with start
//   sum          out  WIDTH-bit result
//   cout         out  carry out of the MSB (for subtract, 1 = no borrow)
//   ovf          out  two's-complement overflow
//   busy         out  high while chunks are being processed
//   shift_next   out  same as busy, one pulse per chunk cycle
//   result_ready out  high while idle
//   done         out  one-cycle pulse when a result becomes valid
interface seq_adder_param_if #(
  parameter int WIDTH = 48
);
  logic             start;
  logic             sub;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             shift_next;
  logic             result_ready;
  logic             done;

  modport master (
    output start, sub, abort, a, b,
    input  sum, cout, ovf, busy, shift_next, result_ready, done
  );

  modport slave (
    input  start, sub, abort, a, b,
    output sum, cout, ovf, busy, shift_next, result_ready, done
  );
endinterface

// File: rtl/seq_adder_param.sv
// rtl/seq_adder_param.sv - multi-cycle adder/subtractor, CHUNK bits per clock
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  seq_adder_param_if.slave: start/sub/abort/a/b in,
//        sum/cout/ovf/busy/shift_next/result_ready/done out
//
// Parameters:
//   WIDTH  operand/result width, an integer multiple of CHUNK
//   CHUNK  bits added per clock cycle
module seq_adder_param #(
  parameter int WIDTH = 48,
  parameter int CHUNK = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_adder_param_if.slave     bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] sumReg;
  logic             carry;
  logic [CW-1:0]    chunkCnt;
  logic             coutReg;
  logic             ovfReg;
  logic             doneReg;

  logic [CHUNK-1:0] chunkSum;
  logic             chunkCarry;
  logic [WIDTH-1:0] sumNext;
  logic             chunkOvf;

  // One chunk of the ripple: low CHUNK bits of the shifting operands plus the
  // carry left over from the previous chunk. The chunk result enters sum at
  // the top so that after NCHUNK cycles the chunks sit in their proper place.
  always_comb begin
    {chunkCarry, chunkSum} = {1'b0, opA[CHUNK-1:0]}
                           + {1'b0, opB[CHUNK-1:0]}
                           + {{CHUNK{1'b0}}, carry};
    sumNext  = (sumReg >> CHUNK) | (WIDTH'(chunkSum) << (WIDTH - CHUNK));
    // B is already inverted for subtract, so the add-overflow rule covers both.
    chunkOvf = (opA[CHUNK-1] == opB[CHUNK-1]) && (chunkSum[CHUNK-1] != opA[CHUNK-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      opA      <= '0;
      opB      <= '0;
      sumReg   <= '0;
      carry    <= 1'b0;
      chunkCnt <= '0;
      coutReg  <= 1'b0;
      ovfReg   <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          // Abort beats a simultaneous start.
          if (bus.start && !bus.abort) begin
            state    <= RUN;
            opA      <= bus.a;
            opB      <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub;
            chunkCnt <= '0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state   <= IDLE;
            sumReg  <= '0;
            coutReg <= 1'b0;
            ovfReg  <= 1'b0;
          end else begin
            opA      <= opA >> CHUNK;
            opB      <= opB >> CHUNK;
            sumReg   <= sumNext;
            carry    <= chunkCarry;
            chunkCnt <= chunkCnt + CW'(1);
            if (chunkCnt == LAST_CHUNK) begin
              state   <= IDLE;
              coutReg <= chunkCarry;
              ovfReg  <= chunkOvf;
              doneReg <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sum          = sumReg;
  assign bus.cout         = coutReg;
  assign bus.ovf          = ovfReg;
  assign bus.done         = doneReg;
  assign bus.busy         = (state == RUN);
  assign bus.shift_next   = (state == RUN);
  assign bus.result_ready = (state == IDLE);

endmodule
